mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 255, busy cycles without memAck before abort; FAIR_LIMIT, default 2, consecutive data grants allowed while fetch waits.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 ifReq  in  1  fetch request; held by requester until ifDone.
REQ-005 ifAddr  in  32  fetch address.
REQ-006 ifRdata  out  32  fetched word; valid while ifDone=1, held afterwards.
REQ-007 ifDone  out  1  one-cycle completion pulse for fetch.
REQ-008 dReq  in  1  data (load/store) request; held until dDone.
REQ-009 dWe  in  1  1=store, 0=load.
REQ-010 dAddr  in  32  data address.
REQ-011 dWdata  in  32  store data.
REQ-012 dRdata  out  32  load data; valid while dDone=1, held afterwards.
REQ-013 dDone  out  1  one-cycle completion pulse for data.
REQ-014 memReq  out  1  registered request to shared memory port.
REQ-015 memWe  out  1  registered write enable.
REQ-016 memAddr  out  32  registered address.
REQ-017 memWdata  out  32  registered write data.
REQ-018 memRdata  in  32  memory read data, valid with memAck.
REQ-019 memAck  in  1  memory completion, one cycle.
REQ-020 isStall  out  1  pipeline stall to hold the pipeline register.
REQ-021 errTimeout  out  1  one-cycle pulse on aborted transaction.

Function
REQ-022 FSM states SHALL be IDLE, DATA_BUSY, FETCH_BUSY.
REQ-023 IDLE: dReq=1 and fairness count < FAIR_LIMIT -> DATA_BUSY; else ifReq=1 -> FETCH_BUSY; else dReq=1 -> DATA_BUSY; else stay.
REQ-024 On grant, memAddr/memWe/memWdata SHALL latch the winner's inputs (memWe=0, memWdata=0 for fetch) and memReq SHALL be 1 from the next cycle.
REQ-025 Busy: memReq and latched fields SHALL stay constant until memAck or timeout.
REQ-026 memAck in busy state: next cycle memReq=0, matching rdata register loads memRdata (loads/fetch only; stores leave dRdata unchanged), matching Done=1 for exactly one cycle, state -> IDLE.
REQ-027 Latency: request seen at edge N -> memReq=1 after edge N; memAck at edge M -> Done=1 after edge M; minimum request-to-Done two cycles.
REQ-028 Returning to IDLE SHALL not grant in the same cycle Done is high; next grant evaluated on the following edge.
REQ-029 Fairness counter: +1 per data grant while ifReq=1, saturating at FAIR_LIMIT; cleared on any fetch grant or when ifReq=0 at a data grant.
REQ-030 Timeout counter (8 bits min, width ceil(log2(TIMEOUT_CYCLES+1))) SHALL clear on grant, increment each busy cycle without memAck; at TIMEOUT_CYCLES: memReq->0, Done pulse with rdata=0, errTimeout pulse, state->IDLE.
REQ-031 memAck in the cycle the count reaches TIMEOUT_CYCLES SHALL win (normal completion, no errTimeout).
REQ-032 memAck in IDLE SHALL be ignored.
REQ-033 Requester dropping its req mid-transaction SHALL not abort; transaction completes, Done still pulses.
REQ-034 isStall (combinational) = (ifReq & !ifDone) | (dReq & !dDone).

Reset
REQ-035 reset=0 SHALL asynchronously force IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, ifRdata=0, dRdata=0, ifDone=0, dDone=0, errTimeout=0, both counters 0, mid-transaction included.
REQ-036 After reset release, first grant SHALL occur on the first posedge with a request.

Verification
REQ-037 Load: dReq=1,dWe=0,dAddr=0x100; memAck 3 cycles after memReq, memRdata=0xCAFEF00D -> memAddr=0x100, dDone one cycle, dRdata=0xCAFEF00D.
REQ-038 Simultaneous ifReq/dReq both held -> grant order data, data, fetch (FAIR_LIMIT=2), then data.
REQ-039 Store dWe=1,dWdata=0x12345678 -> memWe=1,memWdata=0x12345678; dRdata unchanged after dDone.
REQ-040 No memAck, TIMEOUT_CYCLES=4 -> memReq drops after 4 busy cycles; ifDone=1, ifRdata=0, errTimeout=1 same cycle.
REQ-041 reset=0 mid DATA_BUSY -> memReq=0 immediately, no dDone; after release with dReq held, fresh grant issued.
REQ-042 isStall=1 from ifReq rise through cycle before ifDone; 0 in the ifDone cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction-fetch requester
// and a data (load/store) requester. Data is favoured up to FAIR_LIMIT
// back-to-back grants while fetch waits; a busy transaction with no memAck
// for TIMEOUT_CYCLES cycles is aborted with an error pulse.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned FAIR_LIMIT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifRdata,
    output logic        ifDone,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    output logic [31:0] dRdata,
    output logic        dDone,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        isStall,
    output logic        errTimeout
);

    localparam int unsigned TO_BITS   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_W      = (TO_BITS > 8) ? TO_BITS : 8;
    localparam int unsigned FAIR_BITS = $clog2(FAIR_LIMIT + 1);
    localparam int unsigned FAIR_W    = (FAIR_BITS > 1) ? FAIR_BITS : 1;

    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        DATA_BUSY,
        FETCH_BUSY
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_d, mem_we_d;
    logic [31:0]         mem_addr_d, mem_wdata_d;
    logic [31:0]         if_rdata_d, d_rdata_d;
    logic                if_done_d, d_done_d, err_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d, to_cnt_inc;
    logic [FAIR_W-1:0]   fair_cnt_q, fair_cnt_d;
    logic                grant_data, grant_fetch;

    // Stall while a request is outstanding and its completion is not yet visible.
    assign isStall = (ifReq & ~ifDone) | (dReq & ~dDone);

    // Next-state, grant selection and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = memReq;
        mem_we_d    = memWe;
        mem_addr_d  = memAddr;
        mem_wdata_d = memWdata;
        if_rdata_d  = ifRdata;
        d_rdata_d   = dRdata;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        to_cnt_d    = to_cnt_q;
        fair_cnt_d  = fair_cnt_q;
        to_cnt_inc  = to_cnt_q + TO_W'(1);
        grant_data  = 1'b0;
        grant_fetch = 1'b0;

        case (state_q)
            IDLE: begin
                // A Done pulse means the requester has not yet seen completion,
                // so its req is stale for one more edge: no grant this cycle.
                if (!ifDone && !dDone) begin
                    if (dReq && (fair_cnt_q < FAIR_MAX)) begin
                        grant_data = 1'b1;
                    end else if (ifReq) begin
                        grant_fetch = 1'b1;
                    end else if (dReq) begin
                        grant_data = 1'b1;
                    end
                end

                if (grant_data) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dWe;
                    mem_addr_d  = dAddr;
                    mem_wdata_d = dWdata;
                    to_cnt_d    = '0;
                    if (ifReq) begin
                        if (fair_cnt_q < FAIR_MAX) begin
                            fair_cnt_d = fair_cnt_q + FAIR_W'(1);
                        end
                    end else begin
                        fair_cnt_d = '0;
                    end
                end else if (grant_fetch) begin
                    state_d     = FETCH_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ifAddr;
                    mem_wdata_d = '0;
                    to_cnt_d    = '0;
                    fair_cnt_d  = '0;
                end
            end

            DATA_BUSY, FETCH_BUSY: begin
                if (memAck) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == FETCH_BUSY) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = memRdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (!memWe) begin
                            d_rdata_d = memRdata;
                        end
                    end
                end else if (to_cnt_inc == TO_MAX) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    to_cnt_d  = to_cnt_inc;
                    if (state_q == FETCH_BUSY) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            ifRdata    <= '0;
            dRdata     <= '0;
            ifDone     <= 1'b0;
            dDone      <= 1'b0;
            errTimeout <= 1'b0;
            to_cnt_q   <= '0;
            fair_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            memReq     <= mem_req_d;
            memWe      <= mem_we_d;
            memAddr    <= mem_addr_d;
            memWdata   <= mem_wdata_d;
            ifRdata    <= if_rdata_d;
            dRdata     <= d_rdata_d;
            ifDone     <= if_done_d;
            dDone      <= d_done_d;
            errTimeout <= err_d;
            to_cnt_q   <= to_cnt_d;
            fair_cnt_q <= fair_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int TO = 4;
    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReq, dReq, dWe, memAck;
    logic [31:0] ifAddr, dAddr, dWdata, memRdata;
    logic [31:0] ifRdata, dRdata, memAddr, memWdata;
    logic        ifDone, dDone, memReq, memWe, isStall, errTimeout;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .FAIR_LIMIT(FL)) dut (
        .clk(clk), .reset(reset),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
        .dRdata(dRdata), .dDone(dDone),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .isStall(isStall), .errTimeout(errTimeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none, 1=data, 2=fetch; age = busy edges without ack.
    int          owner, age, fair;
    logic        m_memReq, m_memWe, m_ifDone, m_dDone, m_err;
    logic [31:0] m_memAddr, m_memWdata, m_ifRdata, m_dRdata;

    function automatic int winner(input logic d, input logic f, input int fcnt);
        if (d && fcnt < FL) return 1;
        if (f) return 2;
        if (d) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit done_seen;
        bit abort;
        int w;
        if (!reset) begin
            owner = 0; age = 0; fair = 0;
            m_memReq = 0; m_memWe = 0; m_memAddr = 0; m_memWdata = 0;
            m_ifRdata = 0; m_dRdata = 0; m_ifDone = 0; m_dDone = 0; m_err = 0;
        end else begin
            done_seen = m_ifDone | m_dDone;
            m_ifDone = 0; m_dDone = 0; m_err = 0;
            if (owner != 0) begin
                abort = 0;
                if (!memAck) begin
                    age = age + 1;
                    abort = (age == TO);
                end
                if (memAck || abort) begin
                    if (owner == 2) begin
                        m_ifDone  = 1;
                        m_ifRdata = abort ? 32'h0 : memRdata;
                    end else begin
                        m_dDone = 1;
                        if (abort) m_dRdata = 0;
                        else if (!m_memWe) m_dRdata = memRdata;
                    end
                    m_err    = abort;
                    m_memReq = 0;
                    owner    = 0;
                end
            end else if (!done_seen) begin
                w = winner(dReq, ifReq, fair);
                if (w == 1) begin
                    owner = 1; age = 0; m_memReq = 1;
                    m_memWe = dWe; m_memAddr = dAddr; m_memWdata = dWdata;
                    fair = ifReq ? ((fair + 1 > FL) ? FL : fair + 1) : 0;
                end else if (w == 2) begin
                    owner = 2; age = 0; m_memReq = 1;
                    m_memWe = 0; m_memAddr = ifAddr; m_memWdata = 0;
                    fair = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("memReq", memReq, m_memReq);
            chk("memWe", memWe, m_memWe);
            chk("memAddr", memAddr, m_memAddr);
            chk("memWdata", memWdata, m_memWdata);
            chk("ifRdata", ifRdata, m_ifRdata);
            chk("dRdata", dRdata, m_dRdata);
            chk("ifDone", ifDone, m_ifDone);
            chk("dDone", dDone, m_dDone);
            chk("errTimeout", errTimeout, m_err);
            chk("isStall", isStall, (ifReq & ~m_ifDone) | (dReq & ~m_dDone));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] order [4];
    int          waits;

    initial begin
        reset = 0; ifReq = 0; dReq = 0; dWe = 0; memAck = 0;
        ifAddr = 0; dAddr = 0; dWdata = 0; memRdata = 0;
        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_memReq", memReq, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_dRdata", dRdata, 0);
        reset = 1;

        // Load with ack three cycles after memReq
        dReq = 1; dWe = 0; dAddr = 32'h100;
        tick();
        chk("load_memReq", memReq, 1);
        chk("load_memAddr", memAddr, 32'h100);
        chk("load_memWe", memWe, 0);
        tick(); tick();
        memAck = 1; memRdata = 32'hCAFEF00D;
        tick();
        memAck = 0; memRdata = 0;
        chk("load_dDone", dDone, 1);
        chk("load_dRdata", dRdata, 32'hCAFEF00D);
        chk("load_memReq_drop", memReq, 0);
        chk("load_noerr", errTimeout, 0);
        dReq = 0;
        tick();
        chk("load_dDone_pulse", dDone, 0);
        chk("load_dRdata_hold", dRdata, 32'hCAFEF00D);

        // Both requesters held: data, data, fetch, data
        ifReq = 1; ifAddr = 32'h200; dReq = 1; dWe = 0; dAddr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            waits = 0;
            while (memReq !== 1'b1 && waits < 10) begin
                tick();
                waits++;
            end
            chk("fair_grant_wait", waits, (g == 0) ? 1 : 2);
            order[g] = memAddr;
            tick();
            memAck = 1; memRdata = 32'hA0000000 + g;
            tick();
            memAck = 0; memRdata = 0;
        end
        chk("fair_order0", order[0], 32'h300);
        chk("fair_order1", order[1], 32'h300);
        chk("fair_order2", order[2], 32'h200);
        chk("fair_order3", order[3], 32'h300);
        ifReq = 0; dReq = 0;
        tick();
        chk("fair_ifRdata", ifRdata, 32'hA0000002);
        chk("fair_dRdata", dRdata, 32'hA0000003);

        // Store leaves dRdata untouched
        dReq = 1; dWe = 1; dAddr = 32'h400; dWdata = 32'h12345678;
        tick();
        chk("store_memWe", memWe, 1);
        chk("store_memWdata", memWdata, 32'h12345678);
        chk("store_memAddr", memAddr, 32'h400);
        memAck = 1; memRdata = 32'hDEADBEEF;
        tick();
        memAck = 0; memRdata = 0;
        chk("store_dDone", dDone, 1);
        chk("store_dRdata", dRdata, 32'hA0000003);
        dReq = 0; dWe = 0; dWdata = 0;
        tick();

        // Fetch with no ack times out after TO busy cycles
        ifReq = 1; ifAddr = 32'h500;
        #1;
        chk("stall_rise", isStall, 1);
        tick();
        chk("to_memReq", memReq, 1);
        chk("to_memAddr", memAddr, 32'h500);
        chk("to_memWdata", memWdata, 0);
        repeat (TO - 1) tick();
        chk("to_memReq_held", memReq, 1);
        chk("to_stall_busy", isStall, 1);
        tick();
        chk("to_memReq_drop", memReq, 0);
        chk("to_ifDone", ifDone, 1);
        chk("to_ifRdata", ifRdata, 0);
        chk("to_err", errTimeout, 1);
        chk("to_stall_done", isStall, 0);
        ifReq = 0;
        tick();
        chk("to_err_pulse", errTimeout, 0);
        chk("to_ifDone_pulse", ifDone, 0);

        // Ack in the cycle the count reaches the limit wins
        dReq = 1; dWe = 0; dAddr = 32'h600;
        tick();
        repeat (TO - 1) tick();
        memAck = 1; memRdata = 32'h55AA55AA;
        tick();
        memAck = 0; memRdata = 0;
        chk("edge_dDone", dDone, 1);
        chk("edge_noerr", errTimeout, 0);
        chk("edge_dRdata", dRdata, 32'h55AA55AA);
        dReq = 0;
        tick();

        // Ack while idle is ignored
        memAck = 1; memRdata = 32'hFFFFFFFF;
        tick();
        memAck = 0; memRdata = 0;
        chk("idle_ack_dDone", dDone, 0);
        chk("idle_ack_ifDone", ifDone, 0);
        chk("idle_ack_dRdata", dRdata, 32'h55AA55AA);
        chk("idle_ack_memReq", memReq, 0);
        tick();

        // Request dropped mid-transaction still completes
        dReq = 1; dAddr = 32'h700;
        tick();
        dReq = 0;
        tick();
        memAck = 1; memRdata = 32'h13579BDF;
        tick();
        memAck = 0; memRdata = 0;
        chk("drop_dDone", dDone, 1);
        chk("drop_dRdata", dRdata, 32'h13579BDF);
        tick();

        // Reset in the middle of a data transaction
        dReq = 1; dAddr = 32'h800;
        tick();
        chk("rstmid_memReq_before", memReq, 1);
        tick();
        reset = 0;
        #1;
        chk("rstmid_memReq", memReq, 0);
        chk("rstmid_memAddr", memAddr, 0);
        chk("rstmid_dRdata", dRdata, 0);
        tick();
        chk("rstmid_no_dDone", dDone, 0);
        reset = 1;
        tick();
        chk("rstmid_regrant", memReq, 1);
        chk("rstmid_regrant_addr", memAddr, 32'h800);
        memAck = 1; memRdata = 32'h24681357;
        tick();
        memAck = 0; memRdata = 0;
        chk("rstmid_dDone", dDone, 1);
        dReq = 0;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
